mem_arbiter: RTL and testbench

Shares the core's single memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle core. It keeps one transaction outstanding at a time and grants round-robin when both sides request. Responses are steered back to the owning requester, and a stuck memory is bounded by a response timeout. It sits between the fetch/LSU stages and the memory model.

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and memory port bundle around mem_arbiter
// The arbiter takes the slave view; the core stages and memory model take the master view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                      ifu_req_valid;
    logic                      ifu_req_ready;
    logic [ADDR_WIDTH-1:0]     ifu_addr;
    logic                      ifu_resp_valid;
    logic [DATA_WIDTH-1:0]     ifu_rdata;
    logic                      ifu_resp_err;

    logic                      lsu_req_valid;
    logic                      lsu_req_ready;
    logic [ADDR_WIDTH-1:0]     lsu_addr;
    logic                      lsu_wen;
    logic [DATA_WIDTH-1:0]     lsu_wdata;
    logic [DATA_WIDTH/8-1:0]   lsu_wmask;
    logic                      lsu_resp_valid;
    logic [DATA_WIDTH-1:0]     lsu_rdata;
    logic                      lsu_resp_err;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_wen;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic                      mem_resp_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter onto a single memory port
// One transaction in flight; a response timeout turns a stuck memory into an error response.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int         MASK_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    owner_t                  last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;
    logic [7:0]              cnt_q, cnt_d;

    logic grant_ifu, grant_lsu;
    logic resp_fire, resp_err;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie the side that did not win last time goes first.
                grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || last_q == OWN_IFU);
                grant_ifu = bus.ifu_req_valid && !grant_lsu;
                if (grant_lsu) begin
                    addr_d  = bus.lsu_addr;
                    wen_d   = bus.lsu_wen;
                    wdata_d = bus.lsu_wdata;
                    wmask_d = bus.lsu_wmask;
                    owner_d = OWN_LSU;
                    last_d  = OWN_LSU;
                    state_d = S_REQ;
                end else if (grant_ifu) begin
                    addr_d  = bus.ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWN_IFU;
                    last_d  = OWN_IFU;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_d   = S_IDLE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset suppresses both grants and responses so an abandoned transaction never answers.
    logic ifu_resp, lsu_resp;
    logic [DATA_WIDTH-1:0] resp_data;

    assign ifu_resp  = resp_fire && !rst && owner_q == OWN_IFU;
    assign lsu_resp  = resp_fire && !rst && owner_q == OWN_LSU;
    assign resp_data = resp_err ? '0 : bus.mem_rdata;

    assign bus.ifu_req_ready  = grant_ifu && !rst;
    assign bus.lsu_req_ready  = grant_lsu && !rst;

    assign bus.ifu_resp_valid = ifu_resp;
    assign bus.ifu_resp_err   = ifu_resp && resp_err;
    assign bus.ifu_rdata      = ifu_resp ? resp_data : '0;
    assign bus.lsu_resp_valid = lsu_resp;
    assign bus.lsu_resp_err   = lsu_resp && resp_err;
    assign bus.lsu_rdata      = lsu_resp ? resp_data : '0;

    assign bus.mem_req_valid  = state_q == S_REQ;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;

        // Reset state
        next; next;
        sample;
        check("rst_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wen", bus.mem_wen, 0);
        check("rst_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        next;
        rst = 1'b0;
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // Single fetch
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h8000_0000;
        bus.mem_req_ready = 1'b1;
        sample;
        check("fetch_ifu_ready", bus.ifu_req_ready, 1);
        check("fetch_lsu_ready", bus.lsu_req_ready, 0);
        next;
        bus.ifu_req_valid = 1'b0;
        sample;
        check("fetch_mem_valid", bus.mem_req_valid, 1);
        check("fetch_mem_addr", bus.mem_addr, 64'h8000_0000);
        check("fetch_mem_wen", bus.mem_wen, 0);
        next;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0010_0073;
        sample;
        check("fetch_resp_valid", bus.ifu_resp_valid, 1);
        check("fetch_rdata", bus.ifu_rdata, 64'h0010_0073);
        check("fetch_err", bus.ifu_resp_err, 0);
        check("fetch_lsu_resp", bus.lsu_resp_valid, 0);
        check("fetch_lsu_rdata", bus.lsu_rdata, 0);
        next;
        bus.mem_resp_valid = 1'b0;
        sample;
        check("fetch_resp_done", bus.ifu_resp_valid, 0);
        check("fetch_rdata_zero", bus.ifu_rdata, 0);
        next;

        // Store pass-through
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wdata     = 64'hDEAD_BEEF;
        bus.lsu_wmask     = 8'h0F;
        sample;
        check("store_ready", bus.lsu_req_ready, 1);
        next;
        bus.lsu_req_valid = 1'b0;
        sample;
        check("store_mem_valid", bus.mem_req_valid, 1);
        check("store_mem_addr", bus.mem_addr, 64'h8000_1000);
        check("store_mem_wen", bus.mem_wen, 1);
        check("store_mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF);
        check("store_mem_wmask", bus.mem_wmask, 8'h0F);
        next;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h1234;
        sample;
        check("store_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.lsu_resp_err}, 3'b010);
        next;
        bus.mem_resp_valid = 1'b0;

        // Contention from reset: LSU, IFU, LSU, IFU at one transaction per 3 cycles
        rst = 1'b1;
        next;
        rst = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h100;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h200;
        bus.lsu_wen       = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            exp_lsu = (k % 2 == 0);
            sample;
            check($sformatf("tie%0d_grant", k), {bus.ifu_req_ready, bus.lsu_req_ready}, {!exp_lsu, exp_lsu});
            next;
            sample;
            check($sformatf("tie%0d_addr", k), bus.mem_addr, exp_lsu ? 64'h200 : 64'h100);
            check($sformatf("tie%0d_req_ready", k), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            next;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = 64'h1000 + 64'(k);
            sample;
            check($sformatf("tie%0d_resp", k), {bus.ifu_resp_valid, bus.lsu_resp_valid}, {!exp_lsu, exp_lsu});
            check($sformatf("tie%0d_rdata", k), exp_lsu ? bus.lsu_rdata : bus.ifu_rdata, 64'h1000 + 64'(k));
            check($sformatf("tie%0d_wait_ready", k), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            next;
            bus.mem_resp_valid = 1'b0;
        end
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // Memory backpressure with a pending fetch behind the store
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b1;
        bus.lsu_addr      = 64'h300;
        bus.lsu_wdata     = 64'hCAFE_F00D;
        bus.lsu_wmask     = 8'hF0;
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 64'h500;
        bus.mem_req_ready = 1'b0;
        sample;
        check("bp_lsu_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        next;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_wdata     = 64'h0;
        bus.lsu_wmask     = 8'h00;
        for (int i = 0; i < 5; i++) begin
            sample;
            check($sformatf("bp%0d_valid", i), bus.mem_req_valid, 1);
            check($sformatf("bp%0d_fields", i), {bus.mem_addr[15:0], bus.mem_wdata[31:0], bus.mem_wmask},
                  {16'h0300, 32'hCAFE_F00D, 8'hF0});
            check($sformatf("bp%0d_ready", i), {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
            next;
        end
        bus.mem_req_ready = 1'b1;
        sample;
        check("bp_release_valid", bus.mem_req_valid, 1);
        next;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0;
        sample;
        check("bp_resp", {bus.lsu_resp_valid, bus.lsu_resp_err}, 2'b10);
        next;
        bus.mem_resp_valid = 1'b0;
        sample;
        check("bp_fetch_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
        next;
        bus.ifu_req_valid = 1'b0;
        sample;
        check("bp_fetch_addr", bus.mem_addr, 64'h500);
        check("bp_fetch_zeroed", {bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, 0);
        next;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h77;
        sample;
        check("bp_fetch_resp", bus.ifu_rdata, 64'h77);
        next;
        bus.mem_resp_valid = 1'b0;

        // Timeout with TIMEOUT=4: error in the fifth WAIT cycle, late response dropped
        bus.lsu_req_valid = 1'b1;
        bus.lsu_wen       = 1'b0;
        bus.lsu_addr      = 64'h400;
        sample;
        check("to_ready", bus.lsu_req_ready, 1);
        next;
        bus.lsu_req_valid = 1'b0;
        sample;
        check("to_req", bus.mem_req_valid, 1);
        next;
        bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int w = 0; w < 4; w++) begin
            sample;
            check($sformatf("to_wait%0d", w), bus.lsu_resp_valid, 0);
            next;
        end
        sample;
        check("to_err", {bus.lsu_resp_valid, bus.lsu_resp_err}, 2'b11);
        check("to_rdata", bus.lsu_rdata, 0);
        check("to_ifu_quiet", bus.ifu_resp_valid, 0);
        next;
        bus.mem_resp_valid = 1'b1;
        sample;
        check("to_late_resp", {bus.lsu_resp_valid, bus.ifu_resp_valid}, 0);
        check("to_late_rdata", bus.lsu_rdata, 0);
        check("to_idle", bus.mem_req_valid, 0);
        next;
        bus.mem_resp_valid = 1'b0;

        // Reset in WAIT: no response, tie afterwards goes to LSU
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h600;
        sample;
        check("rw_ready", bus.lsu_req_ready, 1);
        next;
        bus.lsu_req_valid = 1'b0;
        sample;
        check("rw_req", bus.mem_req_valid, 1);
        next;
        rst                = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h55;
        sample;
        check("rw_no_resp", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        check("rw_rdata", bus.lsu_rdata, 0);
        next;
        rst               = 1'b0;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_req_valid = 1'b1;
        sample;
        check("rw_mem_idle", bus.mem_req_valid, 0);
        check("rw_after_resp", bus.lsu_resp_valid, 0);
        check("rw_tie_lsu", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b01);
        next;
        bus.ifu_req_valid  = 1'b0;
        bus.lsu_req_valid  = 1'b0;
        bus.mem_resp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
